// File: rtl/vgachargen_map_ctrl.sv
// Map-port sequencer for the VGA text-mode char/colour maps: arbitrates host
// single-beat accesses against a screen-fill engine, one map operation per cycle.
module vgachargen_map_ctrl #(
  parameter int unsigned MAP_DEPTH = 2400,
  parameter int unsigned ADDR_W    = $clog2(MAP_DEPTH),
  parameter int unsigned CH_W      = 8,
  parameter int unsigned COL_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic              host_sel_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [7:0]        host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [7:0]        host_rdata_o,
  input  logic              fill_start_i,
  input  logic [CH_W-1:0]   fill_ch_i,
  input  logic [COL_W-1:0]  fill_col_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic [ADDR_W-1:0] ch_map_addr_o,
  output logic [CH_W-1:0]   ch_map_data_o,
  output logic              ch_map_wen_o,
  output logic [ADDR_W-1:0] col_map_addr_o,
  output logic [COL_W-1:0]  col_map_data_o,
  output logic              col_map_wen_o,
  input  logic [COL_W-1:0]  col_map_rdata_i
);

  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(MAP_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]     fch_q, fch_d;
  logic [COL_W-1:0]    fcol_q, fcol_d;
  logic                prio_host_q, prio_host_d;
  logic                rd1_q, rd1_d, rd1_col_q, rd1_col_d;
  logic                rd2_q, rd2_col_q;

  logic                busy_d, done_d, rvalid_d;
  logic [7:0]          rdata_d;
  logic [ADDR_W-1:0]   ch_addr_d, col_addr_d;
  logic [CH_W-1:0]     ch_data_d;
  logic [COL_W-1:0]    col_data_d;
  logic                ch_wen_d, col_wen_d;

  logic                fill_pend_c, host_win_c, fill_win_c, host_in_range_c;

  // Arbitration: the pointer only matters when both sides want the cycle.
  assign fill_pend_c     = (state_q == FILL);
  assign host_win_c      = host_req_i && (!fill_pend_c || prio_host_q);
  assign fill_win_c      = fill_pend_c && !host_win_c;
  assign host_in_range_c = (host_addr_i < DEPTH_A);
  assign host_gnt_o      = host_win_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fch_d       = fch_q;
    fcol_d      = fcol_q;
    prio_host_d = prio_host_q;
    busy_d      = fill_busy_o;
    done_d      = 1'b0;
    ch_wen_d    = 1'b0;
    col_wen_d   = 1'b0;
    ch_addr_d   = ch_map_addr_o;
    col_addr_d  = col_map_addr_o;
    ch_data_d   = ch_map_data_o;
    col_data_d  = col_map_data_o;
    rd1_d       = 1'b0;
    rd1_col_d   = 1'b0;
    rvalid_d    = rd2_q;
    rdata_d     = rd2_col_q ? 8'(col_map_rdata_i) : 8'd0;

    if (host_req_i && fill_pend_c) begin
      prio_host_d = !host_win_c;
    end

    if (host_win_c) begin
      if (host_we_i) begin
        if (host_in_range_c && host_sel_i) begin
          col_wen_d  = 1'b1;
          col_addr_d = host_addr_i;
          col_data_d = host_wdata_i[COL_W-1:0];
        end else if (host_in_range_c) begin
          ch_wen_d  = 1'b1;
          ch_addr_d = host_addr_i;
          ch_data_d = host_wdata_i[CH_W-1:0];
        end
      end else begin
        rd1_d     = 1'b1;
        rd1_col_d = host_sel_i && host_in_range_c;
        if (host_sel_i) begin
          col_addr_d = host_addr_i;
        end else begin
          ch_addr_d = host_addr_i;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (fill_start_i) begin
          state_d     = FILL;
          cnt_d       = '0;
          fch_d       = fill_ch_i;
          fcol_d      = fill_col_i;
          prio_host_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      FILL: begin
        if (fill_win_c) begin
          ch_wen_d   = 1'b1;
          col_wen_d  = 1'b1;
          ch_addr_d  = cnt_q;
          col_addr_d = cnt_q;
          ch_data_d  = fch_q;
          col_data_d = fcol_q;
          if (cnt_q == LAST_ADDR) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and internal pipeline registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fch_q       <= '0;
      fcol_q      <= '0;
      prio_host_q <= 1'b1;
      rd1_q       <= 1'b0;
      rd1_col_q   <= 1'b0;
      rd2_q       <= 1'b0;
      rd2_col_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fch_q       <= fch_d;
      fcol_q      <= fcol_d;
      prio_host_q <= prio_host_d;
      rd1_q       <= rd1_d;
      rd1_col_q   <= rd1_col_d;
      rd2_q       <= rd1_q;
      rd2_col_q   <= rd1_col_q;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_busy_o    <= 1'b0;
      fill_done_o    <= 1'b0;
      host_rvalid_o  <= 1'b0;
      host_rdata_o   <= '0;
      ch_map_addr_o  <= '0;
      ch_map_data_o  <= '0;
      ch_map_wen_o   <= 1'b0;
      col_map_addr_o <= '0;
      col_map_data_o <= '0;
      col_map_wen_o  <= 1'b0;
    end else begin
      fill_busy_o    <= busy_d;
      fill_done_o    <= done_d;
      host_rvalid_o  <= rvalid_d;
      host_rdata_o   <= rdata_d;
      ch_map_addr_o  <= ch_addr_d;
      ch_map_data_o  <= ch_data_d;
      ch_map_wen_o   <= ch_wen_d;
      col_map_addr_o <= col_addr_d;
      col_map_data_o <= col_data_d;
      col_map_wen_o  <= col_wen_d;
    end
  end

endmodule
